// File: rtl/move_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : move_cmd_sequencer_pkg
//  Description : Shared command constants, response bytes and the sequencer
//                state type used by the move command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package move_cmd_sequencer_pkg;

    // Existing command words
    localparam logic [15:0] c_cal_gyro  = 16'h2000;

    // Response bytes returned by the DUT over RemoteComm
    localparam logic [7:0]  c_ack_byte  = 8'hA5;
    localparam logic [7:0]  c_nack_byte = 8'h5A;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_SENT = 2'd2,
        S_WAIT_ACK  = 2'd3
    } seq_state_t;

endpackage : move_cmd_sequencer_pkg
`default_nettype wire

// File: rtl/move_cmd_sequencer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo
//  Description : DEPTH x WIDTH circular command buffer with wrap-around
//                pointers, registered count/full/empty and a synchronous
//                flush. Head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CW-1:0]    w_count_nxt;

    // A push into a full queue or a pop from an empty one is dropped
    assign w_push_ok = push && !r_full  && !flush;
    assign w_pop_ok  = pop  && !r_empty && !flush;

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage array, written at the tail pointer
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and registered occupancy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/move_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_cmd_sequencer
//  Description : Queues 16-bit move/calibration commands and issues them one
//                at a time to RemoteComm, waiting for an ACK byte and
//                retrying on NACK or response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module move_cmd_sequencer
    import move_cmd_sequencer_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  ACK       = c_ack_byte,
    parameter logic [23:0] TIMEOUT   = 24'd4_000_000,
    parameter int          MAX_RETRY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [15:0]             push_cmd,
    input  logic                    start,
    input  logic                    abort,
    output logic [15:0]             cmd,
    output logic                    send_cmd,
    input  logic                    cmd_sent,
    input  logic                    resp_rdy,
    input  logic [7:0]              resp,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    seq_state_t       r_state;
    logic [15:0]      r_cmd;
    logic             r_send;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [RW-1:0]    r_retry;
    logic [23:0]      r_timer;

    logic [15:0]      w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ack;
    logic             w_pop;
    logic             w_last;
    logic             w_timeout;

    // A good response in WAIT_ACK retires the head entry
    assign w_ack     = resp_rdy && (resp == ACK);
    assign w_pop     = (r_state == S_WAIT_ACK) && w_ack && !abort;
    // Queue becomes empty on this pop unless a push lands in the same cycle
    assign w_last    = (w_count == CW'(1)) && !push;
    assign w_timeout = (r_timer == (TIMEOUT - 24'd1));

    cmd_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (16)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push && !abort),
        .push_data (push_cmd),
        .pop       (w_pop),
        .flush     (abort),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Sequencer FSM with timeout and retry counters. SEND is a two-phase
    // state: the first cycle latches the head into cmd and raises send_cmd,
    // the second drops it. Starting from IDLE skips the first phase because
    // the head is already stable there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cmd   <= 16'h0000;
            r_send  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_retry <= '0;
            r_timer <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_send  <= 1'b0;
                r_busy  <= 1'b0;
                r_retry <= '0;
                r_timer <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_send <= 1'b0;
                        if (start && !w_empty) begin
                            r_state <= S_SEND;
                            r_send  <= 1'b1;
                            r_cmd   <= w_head;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                            r_retry <= '0;
                        end
                    end
                    S_SEND: begin
                        if (r_send) begin
                            r_send  <= 1'b0;
                            r_state <= S_WAIT_SENT;
                        end else begin
                            r_send  <= 1'b1;
                            r_cmd   <= w_head;
                        end
                    end
                    S_WAIT_SENT: begin
                        if (cmd_sent) begin
                            r_state <= S_WAIT_ACK;
                            r_timer <= '0;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (w_ack) begin
                            r_retry <= '0;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_SEND;
                            end
                        end else if (resp_rdy || w_timeout) begin
                            if (r_retry < RW'(MAX_RETRY)) begin
                                r_retry <= r_retry + RW'(1);
                                r_state <= S_SEND;
                            end else begin
                                r_err   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_timer <= r_timer + 24'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_send  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd      = r_cmd;
    assign send_cmd = r_send;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign full     = w_full;
    assign count    = w_count;

endmodule : move_cmd_sequencer
`default_nettype wire

// File: doc/move_cmd_sequencer.md
# move_cmd_sequencer

Queues 16-bit Knight move/calibration commands and issues them one at a time to the RemoteComm command port. After each command it waits for the DUT response byte and retries on NACK or timeout. It sits between a host/test driver and RemoteComm and replaces hand-sequenced send/ack loops with a hardware scheduler.

## Interface
- DEPTH, 8, command queue entries (power of 2, ≥2)
- ACK, 8'hA5, positive-acknowledge response byte
- TIMEOUT, 24'd4_000_000, clk cycles allowed from cmd_sent to resp_rdy
- MAX_RETRY, 2, resends allowed per command after the first attempt
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- push  in  1  enqueue push_cmd this cycle
- push_cmd  in  16  command word
- start  in  1  begin/resume draining the queue
- abort  in  1  stop, flush queue, return idle
- cmd  out  16  command to RemoteComm (head of queue)
- send_cmd  out  1  one-cycle send strobe to RemoteComm
- cmd_sent  in  1  RemoteComm finished transmitting cmd
- resp_rdy  in  1  response byte valid (one-cycle pulse)
- resp  in  8  response byte
- full  out  1  queue holds DEPTH entries
- count  out  $clog2(DEPTH)+1  entries queued
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse: queue drained with all ACKs
- err  out  1  sticky: retries exhausted

## Operation
- FSM states: IDLE, SEND, WAIT_SENT, WAIT_ACK.
- IDLE: start && count≠0 → SEND, clear err, clear retry count. start with count=0 is ignored.
- SEND: assert send_cmd for one cycle → WAIT_SENT.
- WAIT_SENT: on cmd_sent → WAIT_ACK; load the timeout counter with 0.
- WAIT_ACK, resp_rdy with resp==ACK: pop head, clear retry count. If the queue is now empty: pulse done → IDLE; else → SEND.
- WAIT_ACK, resp_rdy with resp≠ACK, or timer reaches TIMEOUT−1: if retry<MAX_RETRY, increment retry → SEND (same head). Otherwise set err → IDLE, head NOT popped, so a later start resends it.
- push when full: ignored, count unchanged. push while busy: allowed, appended to tail.
- Simultaneous push and pop: count unchanged, both take effect.
- resp_rdy outside WAIT_ACK: ignored. cmd_sent outside WAIT_SENT: ignored.
- abort has priority over every other input in every state: → IDLE, count=0, retry=0, no done/err pulse. err is left unchanged. A simultaneous push is dropped.
- cmd = head entry; it is held stable from send_cmd until the head is popped.

## Timing
- Reset values: cmd=16'h0000, send_cmd=0, full=0, count=0, busy=0, done=0, err=0; FSM=IDLE; pointers and retry=0.
- All outputs are registered.
- start sampled at edge N → send_cmd high in cycle N+1 only.
- ACK sampled at edge M → done high in cycle M+1, or send_cmd high in cycle M+2 for the next entry.
- count/full update the cycle after push/pop.
- Timeout fires exactly TIMEOUT cycles after cmd_sent is sampled. A resp_rdy arriving in the same cycle as the timeout wins.
- Reset mid-operation: immediate return to reset values; queue contents are discarded.

## Structure
- Shared package (alongside the existing command constants, e.g. CAL_GYRO): seq_state_t enum, ACK/NACK byte constants.
- One sub-module, cmd_fifo: DEPTH×16 circular buffer with wrap-around pointers, push/pop/count/full/empty, async active-low reset. The FSM and timeout/retry counters live in the top module.

## Test plan
- Push 0x2000 (cal), 0x4BF1, 0x47F1; start; model ACKs each → three send_cmd pulses in order with cmd matching; single done; count returns to 0; err=0.
- Push 0x4BF1; respond 0x5A once, then A5 → send_cmd twice, both with cmd=0x4BF1; done pulses; err=0.
- Push 0x47F1; never respond (TIMEOUT reduced to 100) → 3 send_cmd pulses spaced ≥100 cycles after each cmd_sent; err=1; count=1; busy=0. A second start resends 0x47F1 and clears err.
- Push DEPTH+1 words → full=1, count=DEPTH, last word dropped. Drain with ACKs: cmds emerge FIFO across pointer wrap.
- Push 3 words, start, assert abort in WAIT_ACK → busy=0, count=0, no done; a later resp_rdy is ignored.
- Assert rst_n low during WAIT_SENT → all outputs return to reset values immediately; after release, start with an empty queue produces no send_cmd.
